jtframe_joyser: RTL and testbench

Parametrised serial joystick scanner for boards that daisy-chain joystick ports through 74HC165-style shift registers: one data line, a shared clock, a load strobe and a select line. It scans NJOY ports in two select phases (SEL high / SEL low, for Megadrive-style pads) and publishes active-low button buses to the core. It also provides an unmasked copy for the OSD controller and blanks the core copy while the OSD intercepts input.

---
 rtl/jtframe_joyser_pkg.sv | 6 +
 rtl/jtframe_joyser_deb.sv | 18 +
 rtl/jtframe_joyser.sv | 117 +++++++++++
 tb/tb_jtframe_joyser.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/jtframe_joyser_pkg.sv
// jtframe_joyser_pkg: FSM states and phase timing shared by the joystick scanner files
package jtframe_joyser_pkg;
  typedef enum logic [2:0] {S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_SETTLE, S_PUBLISH} state_e;
  localparam int LOAD_TICKS = 2;
  localparam int SETTLE_TICKS = 4;
endpackage

// File: rtl/jtframe_joyser_deb.sv
// jtframe_joyser_deb: per-bit two-frame agreement filter; a bit follows d_i only when it matches the previous frame
module jtframe_joyser_deb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  input  logic [W-1:0] cur_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] prev_q, diff;
  assign diff = d_i ^ prev_q;
  assign q_o = (d_i & ~diff) | (cur_i & diff);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= '1;
    else if (en_i) prev_q <= d_i;
endmodule

// File: rtl/jtframe_joyser.sv
// jtframe_joyser: two-phase serial scanner for 74HC165 joystick chains with OSD masking.
// Define JTFRAME_JOYSER_DEBOUNCE_EN to require two agreeing frames before a bit is published.
module jtframe_joyser
  import jtframe_joyser_pkg::*;
#(
  parameter int NJOY = 2,
  parameter int NBIT = 8,
  parameter int DIV  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 joy_data,
  output logic                 joy_clk,
  output logic                 joy_load,
  output logic                 joy_sel,
  input  logic                 intercept,
  output logic [NJOY*NBIT-1:0] joy_hi,
  output logic [NJOY*NBIT-1:0] joy_lo,
  output logic [NJOY*NBIT-1:0] osd_hi,
  output logic [NJOY*NBIT-1:0] osd_lo,
  output logic                 frame_done
);
  localparam int NW = NJOY * NBIT;
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(NW) + 1;
  state_e st_q, st_d;
  logic [TW-1:0] tc_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d, sel_q, sel_d, load_q, tick, go_pub;
  logic [NW-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d, osd_hi_q, osd_lo_q;
  logic [2*NW-1:0] osd_nx;
  assign tick = tc_q == TW'(DIV - 1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    sel_d = sel_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    go_pub = 1'b0;
    case (st_q)
      S_LOAD: if (tick) begin
        cnt_d = cnt_q == CW'(LOAD_TICKS - 1) ? '0 : cnt_q + CW'(1);
        st_d = cnt_q == CW'(LOAD_TICKS - 1) ? S_SHIFT_LO : S_LOAD;
      end
      S_SHIFT_LO: if (tick) begin
        st_d = S_SHIFT_HI;
        sh_hi_d = phase_q ? {sh_hi_q[NW-2:0], joy_data} : sh_hi_q;
        sh_lo_d = phase_q ? sh_lo_q : {sh_lo_q[NW-2:0], joy_data};
      end
      S_SHIFT_HI: if (tick) begin
        cnt_d = cnt_q == CW'(NW - 1) ? '0 : cnt_q + CW'(1);
        st_d = cnt_q == CW'(NW - 1) ? S_SETTLE : S_SHIFT_LO;
        sel_d = cnt_q == CW'(NW - 1) ? 1'b0 : sel_q;
      end
      S_SETTLE: if (tick) begin
        cnt_d = cnt_q == CW'(SETTLE_TICKS - 1) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(SETTLE_TICKS - 1)) begin
          st_d = phase_q ? S_LOAD : S_PUBLISH;
          go_pub = !phase_q;
          phase_d = 1'b0;
        end
      end
      S_PUBLISH: begin
        // a tick landing here (DIV=1) counts toward LOAD so the frame length stays exact
        st_d = S_LOAD;
        sel_d = 1'b1;
        phase_d = 1'b1;
        cnt_d = tick ? CW'(1) : '0;
      end
      default: st_d = S_LOAD;
    endcase
  end
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
  jtframe_joyser_deb #(.W(2 * NW)) u_deb (
    .clk  (clk),
    .rst_n(rst_n),
    .en_i (go_pub),
    .d_i  ({sh_hi_q, sh_lo_q}),
    .cur_i({osd_hi_q, osd_lo_q}),
    .q_o  (osd_nx)
  );
`else
  assign osd_nx = {sh_hi_q, sh_lo_q};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tc_q <= '0;
      st_q <= S_LOAD;
      cnt_q <= '0;
      phase_q <= 1'b1;
      sel_q <= 1'b1;
      load_q <= 1'b1;
      sh_hi_q <= '1;
      sh_lo_q <= '1;
      osd_hi_q <= '1;
      osd_lo_q <= '1;
    end else begin
      tc_q <= tick ? '0 : tc_q + TW'(1);
      st_q <= st_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      sel_q <= sel_d;
      load_q <= st_d != S_LOAD;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      if (go_pub) {osd_hi_q, osd_lo_q} <= osd_nx;
    end
  assign joy_clk = st_q == S_SHIFT_HI;
  assign joy_load = load_q;
  assign joy_sel = sel_q;
  assign frame_done = st_q == S_PUBLISH;
  assign osd_hi = osd_hi_q;
  assign osd_lo = osd_lo_q;
  assign joy_hi = intercept ? '1 : osd_hi_q;
  assign joy_lo = intercept ? '1 : osd_lo_q;
endmodule

// File: tb/tb_jtframe_joyser.sv
// tb_jtframe_joyser: directed scoreboard bench with 74HC165 chain models for a default and a wide instance
module tb_jtframe_joyser;
  localparam int NW = 16, FRAME = 2 * (2 + 2 * NW + 4) * 4, LOWSEL = (4 + 2 + 2 * NW + 4) * 4 + 1;
  localparam int NW2 = 36, FRAME2 = 2 * (2 + 2 * NW2 + 4);
  localparam logic [NW2-1:0] W2H = 36'h123456789, W2L = 36'hABCDEF0F0;
  logic clk = 1'b0, rst_n = 1'b0, intercept = 1'b0;
  logic joy_data, joy_clk, joy_load, joy_sel, frame_done;
  logic [NW-1:0] joy_hi, joy_lo, osd_hi, osd_lo;
  logic joy_data2, joy_clk2, joy_load2, joy_sel2, frame_done2;
  logic [NW2-1:0] joy_hi2, joy_lo2, osd_hi2, osd_lo2, sr2;
  logic [NW-1:0] w_hi = '1, w_lo = '1, sr, m_hi, m_lo, p_hi, p_lo, pub_hi, pub_lo;
  logic jcp, jcp2;
  logic [2*NW-1:0] sbq[$];
  int cyc, next_fd, n2, c1, c2;
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  jtframe_joyser dut (
    .clk(clk), .rst_n(rst_n), .joy_data(joy_data), .joy_clk(joy_clk), .joy_load(joy_load),
    .joy_sel(joy_sel), .intercept(intercept), .joy_hi(joy_hi), .joy_lo(joy_lo),
    .osd_hi(osd_hi), .osd_lo(osd_lo), .frame_done(frame_done)
  );
  jtframe_joyser #(.NJOY(3), .NBIT(12), .DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .joy_data(joy_data2), .joy_clk(joy_clk2), .joy_load(joy_load2),
    .joy_sel(joy_sel2), .intercept(intercept), .joy_hi(joy_hi2), .joy_lo(joy_lo2),
    .osd_hi(osd_hi2), .osd_lo(osd_lo2), .frame_done(frame_done2)
  );

  // chain models: parallel load while load is low, shift toward the data pin on joy_clk rise
  assign joy_data = sr[NW-1];
  assign joy_data2 = sr2[NW2-1];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      jcp <= 1'b0;
      sr <= '1;
    end else begin
      jcp <= joy_clk;
      if (!joy_load) sr <= joy_sel ? w_hi : w_lo;
      else if (joy_clk && !jcp) sr <= {sr[NW-2:0], 1'b1};
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      jcp2 <= 1'b0;
      sr2 <= '1;
    end else begin
      jcp2 <= joy_clk2;
      if (!joy_load2) sr2 <= joy_sel2 ? W2H : W2L;
      else if (joy_clk2 && !jcp2) sr2 <= {sr2[NW2-2:0], 1'b1};
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      n2 <= 0;
      c1 <= 0;
      c2 <= 0;
    end else if (frame_done2) begin
      n2 <= n2 + 1;
      if (n2 == 0) c1 <= cyc;
      if (n2 == 1) c2 <= cyc;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_hi = '1; m_lo = '1; p_hi = '1; p_lo = '1; pub_hi = '1; pub_lo = '1;
    sbq.delete();
    next_fd = FRAME;
  endtask

  task automatic push(input logic [NW-1:0] h, input logic [NW-1:0] l);
    w_hi = h;
    w_lo = l;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    for (int i = 0; i < NW; i++) begin
      if (h[i] == p_hi[i]) m_hi[i] = h[i];
      if (l[i] == p_lo[i]) m_lo[i] = l[i];
    end
    p_hi = h;
    p_lo = l;
`else
    m_hi = h;
    m_lo = l;
`endif
    sbq.push_back({m_hi, m_lo});
  endtask

  task automatic wait_frame(input string tag);
    int n, lo;
    logic [2*NW-1:0] e;
    n = 0;
    lo = 0;
    do begin
      @(negedge clk);
      n++;
      if (!joy_sel) lo++;
    end while (!frame_done && n < 2 * FRAME);
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_cyc"}, cyc, next_fd);
    chk({tag, "_sel_lo"}, lo, LOWSEL);
    chk({tag, "_sb"}, sbq.size(), 1);
    e = '1;
    if (sbq.size() > 0) e = sbq.pop_front();
    {pub_hi, pub_lo} = e;
    chk({tag, "_osd_hi"}, osd_hi, pub_hi);
    chk({tag, "_osd_lo"}, osd_lo, pub_lo);
    chk({tag, "_joy_hi"}, joy_hi, pub_hi);
    chk({tag, "_joy_lo"}, joy_lo, pub_lo);
    next_fd += FRAME;
    @(negedge clk);
    chk({tag, "_pulse"}, frame_done, 0);
  endtask

  initial begin
    int k, n;
    logic jp;
    mdl_reset();
    repeat (3) @(negedge clk);
    chk("rst_clk", joy_clk, 0);
    chk("rst_load", joy_load, 1);
    chk("rst_sel", joy_sel, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_osd", {osd_hi, osd_lo}, 32'hFFFFFFFF);
    chk("rst_joy", {joy_hi, joy_lo}, 32'hFFFFFFFF);
    push(16'hFE7F, 16'hFE7F);
    rst_n = 1'b1;
    wait_frame("f1");
    push(16'hAA7F, 16'h557F);
    wait_frame("f2");
    chk("w_cyc1", c1, FRAME2);
    chk("w_cyc2", c2, 2 * FRAME2);
    chk("w_osd_hi", osd_hi2, W2H);
    chk("w_osd_lo", osd_lo2, W2L);
    chk("w_port2", joy_hi2[11:0], 12'h789);
    push(16'hAA7F, 16'h557F);
    repeat (100) @(negedge clk);
    intercept = 1'b1;
    #1;
    chk("icpt_hi", joy_hi, 16'hFFFF);
    chk("icpt_lo", joy_lo, 16'hFFFF);
    chk("icpt_osd", {osd_hi, osd_lo}, {pub_hi, pub_lo});
    @(negedge clk);
    intercept = 1'b0;
    #1;
    chk("rel_hi", joy_hi, pub_hi);
    chk("rel_lo", joy_lo, pub_lo);
    wait_frame("f3");
    w_hi = 16'h1234;
    w_lo = 16'h5678;
    k = 0;
    n = 0;
    jp = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (joy_clk && !jp) k++;
      jp = joy_clk;
    end while (k < 5 && n < FRAME);
    chk("mid_bits", k, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_clk", joy_clk, 0);
    chk("mid_load", joy_load, 1);
    chk("mid_sel", joy_sel, 1);
    chk("mid_osd", {osd_hi, osd_lo}, 32'hFFFFFFFF);
    chk("mid_joy", {joy_hi, joy_lo}, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    mdl_reset();
    push(16'h1234, 16'h5678);
    rst_n = 1'b1;
    wait_frame("f4");
    push(16'hFFFF, 16'hFFFF);
    wait_frame("g1");
    push(16'hFEFF, 16'hFEFF);
    wait_frame("g2");
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    chk("glitch_blocked", osd_hi, 16'hFFFF);
`else
    chk("glitch_passed", osd_hi, 16'hFEFF);
`endif
    push(16'hFFFF, 16'hFFFF);
    wait_frame("g3");
    push(16'hFEFF, 16'hFEFF);
    wait_frame("g4");
    push(16'hFEFF, 16'hFEFF);
    wait_frame("g5");
    chk("held_value", osd_hi, 16'hFEFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
